res_gather_port: RTL and testbench

RES_GATHER_PORT -- requirements
Module: res_gather_port

---
 rtl/res_gather_port_pkg.sv | 26 ++
 rtl/res_bank_fifo.sv | 62 ++++++
 rtl/res_gather_port.sv | 253 +++++++++++++++++++++++++
 tb/tb_res_gather_port.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_gather_port_pkg.sv
// rtl/res_gather_port_pkg.sv - shared state encoding and geometry helpers for the gather port
package res_gather_port_pkg;

    // Transfer sequencing: RUN issues bank reads, FLUSH drains the remaining beats.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Banks concatenated into one output beat.
    function automatic int calc_bpb(input int ow, input int bdw);
        return ow / bdw;
    endfunction

    // Number of bank groups a row is split into.
    function automatic int calc_ng(input int nbank, input int bpb);
        return nbank / bpb;
    endfunction

    // Index width that stays legal when there is only one entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/res_bank_fifo.sv
// rtl/res_bank_fifo.sv - per-bank response FIFO holding returned read data
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i         write push_data_i (caller guarantees not full)
//   pop_i          drop the head entry (caller guarantees not empty)
//   head_o         oldest entry, valid while empty_o is low
//   empty_o/full_o occupancy flags
module res_bank_fifo #(
    parameter int W = 128,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    // D is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(D));

endmodule

// File: rtl/res_gather_port.sv
// rtl/res_gather_port.sv - reads bank groups row by row and assembles wide output beats
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, base_addr,   start a transfer of len beats beginning at row base_addr
//   len
//   bce, braddr         per-bank read strobe and address (bank i in slice i)
//   brdata, brvalid     per-bank read data returns, any latency, in order per bank
//   data_o, out_valid,  assembled beat with valid/ready handshake
//   out_ready
//   busy, done, err     transfer in progress, completion pulse, sticky protocol error
module res_gather_port
    import res_gather_port_pkg::*;
#(
    parameter int NBANK = 8,
    parameter int BDW   = 128,
    parameter int OW    = 256,
    parameter int AW    = 15,
    parameter int LW    = 16,
    parameter int FD    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [LW-1:0]        len,
    output logic [NBANK-1:0]     bce,
    output logic [NBANK*AW-1:0]  braddr,
    input  logic [NBANK*BDW-1:0] brdata,
    input  logic [NBANK-1:0]     brvalid,
    output logic [OW-1:0]        data_o,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int BPB     = calc_bpb(OW, BDW);
    localparam int NG      = calc_ng(NBANK, BPB);
    localparam int GW      = idx_width(NG);
    localparam int CREDITS = FD * NG;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int OCW     = $clog2(FD + 1);

    state_e         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  issued_q, issued_d;
    logic [LW-1:0]  popped_q, popped_d;
    logic [AW-1:0]  row_q, row_d;
    logic [GW-1:0]  ig_q, ig_d;
    logic [GW-1:0]  og_q, og_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic [OCW-1:0] ocnt_q [NBANK];
    logic [OCW-1:0] ocnt_d [NBANK];
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           resync_q, resync_d;

    logic             issue;
    logic             hs;
    logic             grp_ne;
    logic [NBANK-1:0] issue_mask;
    logic [NBANK-1:0] out_sel;
    logic [NBANK-1:0] resp_ok;
    logic [NBANK-1:0] err_evt;
    logic [NBANK-1:0] fifo_push;
    logic [NBANK-1:0] fifo_pop;
    logic [NBANK-1:0] fifo_empty;
    logic [NBANK-1:0] fifo_full;
    logic [BDW-1:0]   fifo_head [NBANK];
    logic [OW-1:0]    beat;

    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
        res_bank_fifo #(
            .W (BDW),
            .D (FD)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (fifo_push[gi]),
            .push_data_i (brdata[gi*BDW +: BDW]),
            .pop_i       (fifo_pop[gi]),
            .head_o      (fifo_head[gi]),
            .empty_o     (fifo_empty[gi]),
            .full_o      (fifo_full[gi])
        );
    end

    // Credits count beats issued but not yet handed out; capping them at
    // FD*NG bounds every bank to FD unconsumed responses because beats are
    // consumed in order and consecutive beats rotate over the groups.
    always_comb begin
        issue      = (state_q == ST_RUN) && (credit_q < CW'(CREDITS));
        issue_mask = '0;
        out_sel    = '0;
        for (int i = 0; i < NBANK; i++) begin
            issue_mask[i] = issue && (GW'(i / BPB) == ig_q);
            out_sel[i]    = (GW'(i / BPB) == og_q);
        end
    end

    always_comb begin
        beat = '0;
        for (int g = 0; g < NG; g++) begin
            if (GW'(g) == og_q) begin
                for (int b = 0; b < BPB; b++) begin
                    beat[b*BDW +: BDW] = fifo_head[g*BPB + b];
                end
            end
        end
        grp_ne    = &(~fifo_empty | ~out_sel);
        out_valid = (state_q != ST_IDLE) && grp_ne;
        hs        = out_valid && out_ready;
        fifo_pop  = hs ? out_sel : '0;
    end

    // A response is expected when a read is outstanding or is being issued
    // this very cycle (zero-latency banks). Until the first accepted start
    // after reset, unexpected responses are stragglers from an abandoned
    // transfer and are dropped without flagging an error.
    always_comb begin
        for (int i = 0; i < NBANK; i++) begin
            resp_ok[i]   = (ocnt_q[i] != '0) || issue_mask[i];
            fifo_push[i] = brvalid[i] && resp_ok[i] && !fifo_full[i];
            err_evt[i]   = brvalid[i] && (resp_ok[i] ? fifo_full[i] : !resync_q);
            ocnt_d[i]    = ocnt_q[i];
            case ({issue_mask[i], brvalid[i] && resp_ok[i]})
                2'b10:   ocnt_d[i] = ocnt_q[i] + OCW'(1);
                2'b01:   ocnt_d[i] = ocnt_q[i] - OCW'(1);
                default: ocnt_d[i] = ocnt_q[i];
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        row_d    = row_q;
        ig_d     = ig_q;
        og_d     = og_q;
        credit_d = credit_q;
        err_d    = err_q;
        done_d   = 1'b0;
        resync_d = resync_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d    = 1'b0;
                    resync_d = 1'b0;
                    if (len != '0) begin
                        state_d  = ST_RUN;
                        len_d    = len;
                        row_d    = base_addr;
                        ig_d     = '0;
                        og_d     = '0;
                        issued_d = '0;
                        popped_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue && (issued_q == len_q - LW'(1))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (hs && (popped_q == len_q - LW'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            issued_d = issued_q + LW'(1);
            if (ig_q == GW'(NG - 1)) begin
                ig_d  = '0;
                row_d = row_q + AW'(1);
            end else begin
                ig_d = ig_q + GW'(1);
            end
        end

        if (hs) begin
            popped_d = popped_q + LW'(1);
            og_d     = (og_q == GW'(NG - 1)) ? '0 : og_q + GW'(1);
        end

        case ({issue, hs})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase

        if (|err_evt) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            row_q    <= '0;
            ig_q     <= '0;
            og_q     <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            resync_q <= 1'b1;
            for (int i = 0; i < NBANK; i++) begin
                ocnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            row_q    <= row_d;
            ig_q     <= ig_d;
            og_q     <= og_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            done_q   <= done_d;
            resync_q <= resync_d;
            for (int i = 0; i < NBANK; i++) begin
                ocnt_q[i] <= ocnt_d[i];
            end
        end
    end

    always_comb begin
        bce    = issue_mask;
        braddr = '0;
        for (int i = 0; i < NBANK; i++) begin
            braddr[i*AW +: AW] = issue_mask[i] ? row_q : '0;
        end
    end

    assign data_o = out_valid ? beat : '0;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_res_gather_port.sv
// tb/tb_res_gather_port.sv - randomized self-checking bench for res_gather_port
module tb_res_gather_port;
    localparam int NBANK = 8;
    localparam int BDW   = 128;
    localparam int OW    = 256;
    localparam int AW    = 15;
    localparam int LW    = 16;
    localparam int FD    = 4;
    localparam int NG    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [LW-1:0]        len;
    logic [NBANK-1:0]     bce;
    logic [NBANK*AW-1:0]  braddr;
    logic [NBANK*BDW-1:0] brdata;
    logic [NBANK-1:0]     brvalid;
    logic [OW-1:0]        data_o;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int             lat [NBANK];
    logic [127:0]   resp_d [NBANK][64];
    int             resp_t [NBANK][64];
    int             wp [NBANK];
    int             rp [NBANK];
    logic [NBANK-1:0] spur;
    logic [31:0]    salt;
    int             t_base, t_len, iss_k, hs_k, last_hs_cyc;
    bit             done_seen, chk_err, prev_stall;
    logic [OW-1:0]  prev_data;
    logic [AW-1:0]  addr4_seen;
    logic [7:0]     exp_mask;

    res_gather_port #(
        .NBANK(NBANK), .BDW(BDW), .OW(OW), .AW(AW), .LW(LW), .FD(FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bce       (bce),
        .braddr    (braddr),
        .brdata    (brdata),
        .brvalid   (brvalid),
        .data_o    (data_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bank contents: a unique word per (bank, row) for the current transfer.
    function automatic logic [127:0] mem_word(input int b, input int a);
        return {salt ^ 32'(b * 32'h01010101), 32'(a), 32'(b), salt + 32'(a * 7)};
    endfunction

    // Beat k comes from group k mod NG at row base + k div NG.
    function automatic logic [OW-1:0] exp_beat(input int k);
        int g;
        int a;
        g = k % NG;
        a = (t_base + k / NG) % (1 << AW);
        return {mem_word(2 * g + 1, a), mem_word(2 * g, a)};
    endfunction

    // Bank models plus monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NBANK; i++) begin
            if (!rst && bce[i]) begin
                resp_d[i][wp[i] % 64] = mem_word(i, int'(braddr[i*AW +: AW]));
                resp_t[i][wp[i] % 64] = cyc + lat[i];
                wp[i]++;
            end
            brvalid[i] = 1'b0;
            brdata[i*BDW +: BDW] = '0;
            if (rp[i] != wp[i] && resp_t[i][rp[i] % 64] <= cyc) begin
                brvalid[i] = 1'b1;
                brdata[i*BDW +: BDW] = resp_d[i][rp[i] % 64];
                rp[i]++;
            end
            if (spur[i]) begin
                brvalid[i] = 1'b1;
                brdata[i*BDW +: BDW] = {4{$urandom}};
            end
        end
        spur = '0;

        if (!rst) begin
            if (bce != '0) begin
                exp_mask = 8'b11 << (2 * (iss_k % NG));
                chk("issue_mask", bce, exp_mask);
                chk("issue_addr_lo", braddr[(2 * (iss_k % NG)) * AW +: AW], (t_base + iss_k / NG) % (1 << AW));
                chk("issue_addr_hi", braddr[(2 * (iss_k % NG) + 1) * AW +: AW], (t_base + iss_k / NG) % (1 << AW));
                if (iss_k == 4) addr4_seen = braddr[0 +: AW];
                chk("issue_in_len", iss_k < t_len, 1);
                iss_k++;
                chk("credit_cap", (iss_k - hs_k) <= FD * NG, 1);
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", data_o, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_o;
            if (out_valid && out_ready) begin
                chk("beat", data_o, exp_beat(hs_k));
                hs_k++;
                if (hs_k == t_len) last_hs_cyc = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                chk("done_beats", hs_k, t_len);
                chk("done_busy", busy, 0);
                if (t_len != 0) chk("done_lat", cyc, last_hs_cyc + 1);
            end
            if (chk_err) chk("err_clear", err, 0);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run(input logic [AW-1:0] b, input int l, input int stall, input bit rnd);
        int n;
        salt = $urandom;
        t_base = int'(b);
        t_len = l;
        iss_k = 0;
        hs_k = 0;
        done_seen = 1'b0;
        last_hs_cyc = -10;
        addr4_seen = '1;
        base_addr = b;
        len = LW'(l);
        start = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        len = LW'($urandom);
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
        chk_err = 1'b1;
        n = 0;
        while (!done_seen && n < 3000) begin
            if (stall > 0 && n == stall) chk("stall_issued", iss_k, (l < 16) ? l : 16);
            if (n < stall) out_ready = 1'b0;
            else if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
            start = (n == 3) && busy && rnd;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("issued_all", iss_k, l);
        chk("beats_all", hs_k, l);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bce"}, bce, 0);
        chk({tag, "_braddr"}, braddr, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        out_ready = 1'b0;
        brvalid = '0;
        brdata = '0;
        spur = '0;
        chk_err = 1'b0;
        prev_stall = 1'b0;
        salt = 32'h1234_5678;
        t_len = 0;
        for (int i = 0; i < NBANK; i++) lat[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero latency, always ready, base 0x10.
        run(15'h10, 8, 0, 0);

        // Random per-bank latencies, random backpressure and bases.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NBANK; i++) lat[i] = $urandom_range(1, 7);
            run(AW'($urandom), $urandom_range(1, 40), 0, 1);
        end

        // Consumer stalled for 20 cycles.
        for (int i = 0; i < NBANK; i++) lat[i] = $urandom_range(1, 7);
        run(AW'($urandom), 32, 20, 0);

        // Row address wraps past the top of the bank.
        run(15'h7FFF, 8, 0, 1);
        chk("wrap_addr", addr4_seen, 0);

        // len = 0, then a spurious response.
        chk_err = 1'b0;
        t_len = 0;
        iss_k = 0;
        hs_k = 0;
        base_addr = AW'(5);
        len = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("len0_busy_later", busy, 0);
            chk("len0_done_once", done, 0);
        end
        chk("len0_no_issue", iss_k, 0);
        spur = 8'b0000_1000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("spur_err", err, 1);
        run(AW'($urandom), 10, 0, 1);

        // Reset in the middle of a transfer.
        for (int i = 0; i < NBANK; i++) lat[i] = $urandom_range(1, 7);
        salt = $urandom;
        t_base = int'(15'h0200);
        t_len = 24;
        iss_k = 0;
        hs_k = 0;
        done_seen = 1'b0;
        base_addr = 15'h0200;
        len = 16'd24;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (hs_k < 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_beat3", hs_k >= 3, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", done, 0);
        end
        chk("no_err_after_rst", err, 0);
        chk("no_done_seen", done_seen, 0);
        run(AW'($urandom), 12, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
